// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2) before DONE.
module uart_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int SAMPLING_RATE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  parity,
    output logic                  tx,
    output logic                  ready,
    output logic                  done,
    output logic [2:0]            fsm_state
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam int CW = $clog2(SAMPLING_RATE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_STOP2  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         clk_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  par_en;
    logic                  par_bit;
    logic                  tx_next;
    logic                  accept;
    logic                  bit_end;

    assign accept  = start && (state == S_IDLE);
    assign bit_end = (clk_cnt == CW'(SAMPLING_RATE - 1));

    // State register plus datapath; tx is loaded with the value of the bit being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            state     <= state_next;
            tx        <= tx_next;
            shift_reg <= shift_next;
            if (accept) begin
                par_en  <= parity;
                par_bit <= ^data;
            end
            if (accept || state == S_IDLE || state == S_DONE || bit_end)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;
            if (state == S_START && bit_end)
                bit_cnt <= BW'(DATA_WIDTH - 1);
            else if (state == S_DATA && bit_end && bit_cnt != '0)
                bit_cnt <= bit_cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_START;
                    shift_next = data;
                end
            end
            S_START: if (bit_end) state_next = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == '0)
                        state_next = par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_end) state_next = S_STOP;
`ifdef UART_TX_TWO_STOP_EN
            S_STOP:   if (bit_end) state_next = S_STOP2;
            S_STOP2:  if (bit_end) state_next = S_DONE;
`else
            S_STOP:   if (bit_end) state_next = S_DONE;
`endif
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // tx_next is decoded from the state being entered so tx changes on the bit's first edge.
    always_comb begin
        tx_next   = 1'b1;
        ready     = (state == S_IDLE);
        done      = (state == S_DONE);
        fsm_state = state;
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = par_bit;
            default:  tx_next = 1'b1;
        endcase
    end

endmodule
